// File: rtl/srt_norm_iter.sv
`timescale 1ns/1ps
// srt_norm_iter
// Iterative operand normaliser for the SRT divider front end. An accepted
// operand is shifted left, up to STEP redundant bits per cycle, until it is
// normalised (unsigned: MSB set; signed: two top bits differ) or the total
// shift reaches WID-1. The result and the shift count are then held until
// the consumer takes them.
//
// Optional feature: define SRT_NORM_DEGEN_EN to short-circuit degenerate
// operands (unsigned 0, signed 0, signed all-ones). They then return
// unchanged after a single SHIFT cycle with shamt_o=0 and degen_o=1. Without
// the macro they run to the shift cap and degen_o is tied low.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   in_valid_i   operand valid
//   in_ready_o   block can accept an operand
//   d_i          operand (WID bits)
//   signed_i     1 = two's-complement mode, sampled with d_i
//   out_valid_o  result valid
//   out_ready_i  consumer accepts the result
//   d_o          normalised operand (0 when no result is held)
//   shamt_o      total left shift applied (0 when no result is held)
//   degen_o      operand had no normalising bit (SRT_NORM_DEGEN_EN only)
module srt_norm_iter #(
    parameter int WID  = 32,
    parameter int STEP = 4,
    parameter int CW   = $clog2(WID)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [WID-1:0] d_i,
    input  logic           signed_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [WID-1:0] d_o,
    output logic [CW-1:0]  shamt_o,
    output logic           degen_o
);

    localparam logic [CW:0] STEP_W = (CW+1)'(STEP);
    localparam logic [CW:0] CAP_W  = (CW+1)'(WID-1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state;
    state_t         state_nxt;

    logic [WID-1:0] r;          // working register
    logic           mode_s;     // latched signed_i
    logic [CW-1:0]  acc;        // shift applied so far
    logic [CW:0]    kraw;
    logic [CW:0]    rem;
    logic [CW:0]    k;
    logic [CW:0]    acc_sum;
    logic           term;
    logic           degen_hit;
    logic           load;

    // Redundant leading bits inside the STEP-wide window below the MSB
    // (signed) or starting at the MSB (unsigned). Saturates at STEP.
    function automatic logic [CW:0] lead_count(input logic [WID-1:0] v,
                                                input logic           sgn);
        logic [CW:0] n;
        logic        run;
        logic        b;
        n   = '0;
        run = 1'b1;
        for (int i = 0; i < STEP; i++) begin
            b   = sgn ? (v[WID-2-i] == v[WID-1]) : ~v[WID-1-i];
            run = run & b;
            n   = n + {{CW{1'b0}}, run};
        end
        return n;
    endfunction

`ifdef SRT_NORM_DEGEN_EN
    logic degen_q;

    function automatic logic is_degen(input logic [WID-1:0] v, input logic sgn);
        return (v == '0) || (sgn && (v == {WID{1'b1}}));
    endfunction
`endif

    // Per-cycle step: shift by the redundant bits found, clipped to the
    // remaining budget so the total never exceeds WID-1.
    always_comb begin
        kraw      = lead_count(r, mode_s);
        rem       = CAP_W - {1'b0, acc};
        k         = (kraw < rem) ? kraw : rem;
        acc_sum   = {1'b0, acc} + k;
        term      = (kraw < STEP_W) || (acc_sum == CAP_W);
        degen_hit = 1'b0;
`ifdef SRT_NORM_DEGEN_EN
        // acc is zero only in the first SHIFT cycle: every non-final cycle
        // advances it by STEP.
        degen_hit = (acc == '0) && is_degen(r, mode_s);
`endif
    end

    assign in_ready_o = ~rst & ((state == IDLE) | ((state == DONE) & out_ready_i));
    assign load       = in_valid_i & in_ready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = SHIFT;
            SHIFT:   if (degen_hit || term) state_nxt = DONE;
            DONE:    if (out_ready_i) state_nxt = load ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers carry no reset; the state register alone decides
    // whether their contents are visible.
    always_ff @(posedge clk) begin
        if (load) begin
            r      <= d_i;
            mode_s <= signed_i;
            acc    <= '0;
`ifdef SRT_NORM_DEGEN_EN
            degen_q <= 1'b0;
`endif
        end else if (state == SHIFT) begin
            if (degen_hit) begin
`ifdef SRT_NORM_DEGEN_EN
                degen_q <= 1'b1;
`endif
            end else begin
                r   <= r << k;
                acc <= acc_sum[CW-1:0];
            end
        end
    end

    assign out_valid_o = (state == DONE);
    assign d_o         = (state == DONE) ? r   : '0;
    assign shamt_o     = (state == DONE) ? acc : '0;
`ifdef SRT_NORM_DEGEN_EN
    assign degen_o     = (state == DONE) & degen_q;
`else
    assign degen_o     = 1'b0;
`endif

endmodule

// File: tb/tb_srt_norm_iter.sv
`timescale 1ns/1ps
module tb_srt_norm_iter;

    localparam int WID = 32;
    localparam int CW  = $clog2(WID);

    typedef struct packed {
        logic [WID-1:0] d;
        logic [CW-1:0]  sh;
        logic           dg;
        int             cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic done [3];

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, got, exp);
        end
    endtask

    // Reference: count the leading redundant bits over the whole word, cap
    // at WID-1, shift, and derive the expected SHIFT-cycle count.
    function automatic exp_t model(input logic [WID-1:0] d, input logic s, input int st);
        exp_t e;
        int   n;
        n = 0;
        if (!s) begin
            for (int i = WID - 1; i >= 0; i--) begin
                if (d[i]) break;
                n++;
            end
        end else begin
            for (int i = WID - 1; i >= 0; i--) begin
                if (d[i] != d[WID-1]) break;
                n++;
            end
            n = n - 1;
        end
        if (n > WID - 1) n = WID - 1;
        e.d   = d << n;
        e.sh  = CW'(n);
        e.dg  = 1'b0;
        e.cyc = (n < WID - 1) ? (n / st + 1) : ((WID - 1 + st - 1) / st);
`ifdef SRT_NORM_DEGEN_EN
        if (d == '0 || (s && d == {WID{1'b1}})) begin
            e.d   = d;
            e.sh  = '0;
            e.dg  = 1'b1;
            e.cyc = 1;
        end
`endif
        return e;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int ST = (g == 0) ? 4 : ((g == 1) ? 1 : WID - 1);

        logic           rst, in_valid, in_ready, sgn;
        logic           out_valid, out_ready, degen, rand_rdy;
        logic [WID-1:0] d_in, d_out;
        logic [CW-1:0]  shamt;
        exp_t           q[$];
        int             acc_q[$];
        logic           seen;

        srt_norm_iter #(.WID(WID), .STEP(ST)) dut (
            .clk         (clk),
            .rst         (rst),
            .in_valid_i  (in_valid),
            .in_ready_o  (in_ready),
            .d_i         (d_in),
            .signed_i    (sgn),
            .out_valid_o (out_valid),
            .out_ready_i (out_ready),
            .d_o         (d_out),
            .shamt_o     (shamt),
            .degen_o     (degen)
        );

        task automatic issue(input logic [WID-1:0] d, input logic s);
            logic acc;
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
            in_valid = 1'b1;
            d_in     = d;
            sgn      = s;
            acc      = 1'b0;
            for (int t = 0; t < 400 && !acc; t++) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
            end
            check($sformatf("step%0d_accept_timeout", ST), 64'(acc), 64'(1));
            in_valid = 1'b0;
        endtask

        task automatic wait_valid(input string nm);
            logic ok;
            ok = 1'b0;
            for (int t = 0; t < 100 && !ok; t++) begin
                @(negedge clk);
                ok = out_valid;
            end
            check($sformatf("step%0d_%s_timeout", ST, nm), 64'(ok), 64'(1));
        endtask

        // Scoreboard monitor: push on accept, compare on first valid and on retire.
        initial begin
            exp_t  e;
            int    lat;
            string t;
            t    = $sformatf("step%0d", ST);
            seen = 1'b0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    q.delete();
                    acc_q.delete();
                    seen = 1'b0;
                end else begin
                    if (out_valid) begin
                        if (q.size() == 0) begin
                            check({t, "_unexpected_valid"}, 64'(out_valid), 64'(0));
                        end else begin
                            e = q[0];
                            if (!seen) begin
                                seen = 1'b1;
                                lat  = cyc - acc_q.pop_front();
                                check({t, "_latency"}, 64'(lat), 64'(e.cyc));
                                check({t, "_d"}, 64'(d_out), 64'(e.d));
                                check({t, "_shamt"}, 64'(shamt), 64'(e.sh));
                                check({t, "_degen"}, 64'(degen), 64'(e.dg));
                            end
                            check({t, "_in_ready_done"}, 64'(in_ready), 64'(out_ready));
                            if (out_ready) begin
                                check({t, "_d_hold"}, 64'(d_out), 64'(e.d));
                                check({t, "_shamt_hold"}, 64'(shamt), 64'(e.sh));
                                check({t, "_degen_hold"}, 64'(degen), 64'(e.dg));
                                void'(q.pop_front());
                                seen = 1'b0;
                            end
                        end
                    end
                    if (in_valid && in_ready) begin
                        q.push_back(model(d_in, sgn, ST));
                        acc_q.push_back(cyc + 1);
                    end
                end
            end
        end

        // Stimulus: directed cases, then randomised operands with random backpressure.
        initial begin
            int    nv;
            string t;
            t        = $sformatf("step%0d", ST);
            done[g]  = 1'b0;
            rst      = 1'b1;
            in_valid = 1'b0;
            out_ready = 1'b0;
            sgn      = 1'b0;
            d_in     = '0;
            rand_rdy = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            check({t, "_rst_valid"}, 64'(out_valid), 64'(0));
            check({t, "_rst_d"}, 64'(d_out), 64'(0));
            check({t, "_rst_shamt"}, 64'(shamt), 64'(0));
            check({t, "_rst_degen"}, 64'(degen), 64'(0));
            check({t, "_rst_in_ready"}, 64'(in_ready), 64'(0));
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            check({t, "_idle_ready"}, 64'(in_ready), 64'(1));

            // Backpressure with a held result, then retire + accept on one edge.
            issue(32'h0000_1234, 1'b0);
            wait_valid("bp");
            check({t, "_bp_d"}, 64'(d_out), 64'h91A0_0000);
            check({t, "_bp_shamt"}, 64'(shamt), 64'(19));
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                #1;
                @(negedge clk);
                check({t, "_bp_valid"}, 64'(out_valid), 64'(1));
                check({t, "_bp_in_ready"}, 64'(in_ready), 64'(0));
                check({t, "_bp_d_stable"}, 64'(d_out), 64'h91A0_0000);
                check({t, "_bp_shamt_stable"}, 64'(shamt), 64'(19));
            end
            @(posedge clk);
            #1;
            in_valid  = 1'b1;
            d_in      = 32'hFFFF_F000;
            sgn       = 1'b1;
            out_ready = 1'b1;
            @(negedge clk);
            check({t, "_b2b_ready"}, 64'(in_ready), 64'(1));
            check({t, "_b2b_valid"}, 64'(out_valid), 64'(1));
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            @(negedge clk);
            check({t, "_b2b_shift"}, 64'(out_valid), 64'(0));
            wait_valid("neg");
            check({t, "_neg_d"}, 64'(d_out), 64'h8000_0000);
            check({t, "_neg_shamt"}, 64'(shamt), 64'(19));

            issue(32'h4000_0000, 1'b1);
            wait_valid("pos");
            check({t, "_pos_d"}, 64'(d_out), 64'h4000_0000);
            check({t, "_pos_shamt"}, 64'(shamt), 64'(0));

            issue(32'h0000_0000, 1'b0);
            wait_valid("zero");
            check({t, "_zero_d"}, 64'(d_out), 64'(0));
`ifdef SRT_NORM_DEGEN_EN
            check({t, "_zero_shamt"}, 64'(shamt), 64'(0));
            check({t, "_zero_degen"}, 64'(degen), 64'(1));
`else
            check({t, "_zero_shamt"}, 64'(shamt), 64'(31));
            check({t, "_zero_degen"}, 64'(degen), 64'(0));
`endif

            // Reset during the third SHIFT cycle of a long operation.
            issue(32'h0000_0001, 1'b0);
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            rst = 1'b1;
            @(negedge clk);
            check({t, "_rst_mid_ready"}, 64'(in_ready), 64'(0));
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            check({t, "_rst_mid_valid"}, 64'(out_valid), 64'(0));
            check({t, "_rst_mid_shamt"}, 64'(shamt), 64'(0));
            check({t, "_rst_mid_d"}, 64'(d_out), 64'(0));
            check({t, "_rst_mid_in_ready"}, 64'(in_ready), 64'(1));
            nv = 0;
            repeat (40) begin
                @(negedge clk);
                if (out_valid) nv++;
            end
            check({t, "_stale_result"}, 64'(nv), 64'(0));

            // Randomised operands, both modes, all leading-bit depths.
            rand_rdy = 1'b1;
            for (int n = 0; n < 60; n++) begin
                logic [WID-1:0] base;
                int             sh;
                logic           s;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                base = $urandom;
                sh   = $urandom_range(0, WID);
                s    = 1'($urandom_range(0, 1));
                base = (sh >= WID) ? '0 : (base >> sh);
                if (s && $urandom_range(0, 1) == 1) base = ~base;
                issue(base, s);
            end
            for (int k = 0; k < 600 && q.size() != 0; k++) begin
                @(posedge clk);
                #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
            check({t, "_drain"}, 64'(q.size()), 64'(0));
            done[g] = 1'b1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: cycle=%0d required all configs finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        wait (done[0] === 1'b1 && done[1] === 1'b1 && done[2] === 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
